// File: rtl/ram_bus_master.sv
// Bus initiator for the 16x8 shared-bus RAM: burst commands in, RAM strobes and tristate bus out, read stream back.
// Every burst passes through one TURN cycle so the RAM and this block never drive the bus together.
module ram_bus_master #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    inout  wire  [DATA_W-1:0] bus,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_enable,
    output logic              ram_write,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [ADDR_W-1:0] cmd_len,
    input  logic [DATA_W-1:0] wdata,
    input  logic              wvalid,
    output logic              wready,
    output logic [DATA_W-1:0] rdata,
    output logic              rvalid,
    input  logic              rready,
    output logic              busy,
    output logic              done
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_TURN,
        S_READ,
        S_WRITE
    } state_t;

    state_t              r_state;
    logic                r_dir;
    logic [ADDR_W-1:0]   r_cur;
    logic [ADDR_W-1:0]   r_cnt;
    logic [DATA_W-1:0]   r_rdata;
    logic                r_rvalid;
    logic                r_done;

    logic                w_rd_fire;
    logic                w_wr_fire;
    logic                w_beat;

    // A read beat may only capture when the output holding register is free or draining.
    assign w_rd_fire = (r_state == S_READ) && (!r_rvalid || rready);
    assign w_wr_fire = (r_state == S_WRITE) && wvalid;
    assign w_beat    = w_rd_fire || w_wr_fire;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_dir    <= 1'b0;
            r_cur    <= '0;
            r_cnt    <= '0;
            r_rdata  <= '0;
            r_rvalid <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (w_rd_fire) begin
                r_rdata  <= bus;
                r_rvalid <= 1'b1;
            end else if (rready) begin
                r_rvalid <= 1'b0;
            end
            case (r_state)
                S_IDLE: begin
                    if (cmd_valid) begin
                        r_cur   <= cmd_addr;
                        r_cnt   <= cmd_len;
                        r_dir   <= cmd_write;
                        r_state <= S_TURN;
                    end
                end
                S_TURN: r_state <= r_dir ? S_WRITE : S_READ;
                S_READ, S_WRITE: begin
                    if (w_beat) begin
                        r_cur <= r_cur + 1'b1;
                        r_cnt <= r_cnt - 1'b1;
                        if (r_cnt == '0) begin
                            r_state <= S_IDLE;
                            r_done  <= 1'b1;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Strobes decode straight from the state register so an async reset drops them at once.
    assign ram_addr   = r_cur;
    assign ram_enable = (r_state == S_READ);
    assign wready     = (r_state == S_WRITE);
    assign ram_write  = wready && wvalid;
    assign bus        = wready ? wdata : {DATA_W{1'bz}};
    assign cmd_ready  = (r_state == S_IDLE) && rst_n;
    assign busy       = (r_state != S_IDLE);
    assign done       = r_done;
    assign rdata      = r_rdata;
    assign rvalid     = r_rvalid;

endmodule

// File: tb/tb_ram_bus_master.sv
// Bench for ram_bus_master: behavioural RAM on the shared bus plus a reference memory image and
// per-beat expectations computed from address/length arithmetic.
module tb_ram_bus_master;

    logic       clk = 1'b0;
    logic       rst_n;
    wire  [7:0] bus;
    logic [3:0] ram_addr;
    logic       ram_enable, ram_write;
    logic       cmd_valid, cmd_ready, cmd_write;
    logic [3:0] cmd_addr, cmd_len;
    logic [7:0] wdata, rdata;
    logic       wvalid, wready, rvalid, rready, busy, done;

    int checks = 0;
    int errors = 0;
    int wr_cnt = 0;
    int done_cnt = 0;

    logic [7:0] ram_mem [16];
    logic [7:0] ref_mem [16];
    logic       init_ram;
    logic       prev_act, prev_busy;

    always #5 clk = ~clk;

    ram_bus_master #(.ADDR_W(4), .DATA_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus),
        .ram_addr(ram_addr), .ram_enable(ram_enable), .ram_write(ram_write),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_len(cmd_len),
        .wdata(wdata), .wvalid(wvalid), .wready(wready),
        .rdata(rdata), .rvalid(rvalid), .rready(rready),
        .busy(busy), .done(done)
    );

    // Behavioural 16x8 RAM sharing the bus.
    assign bus = ram_enable ? ram_mem[ram_addr] : 8'bz;
    always @(posedge clk) begin
        if (init_ram) begin
            for (int i = 0; i < 16; i++) ram_mem[i] <= 8'(i * 37 + 11);
        end else if (ram_write) begin
            ram_mem[ram_addr] <= bus;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            chk("bus_exclusive", {31'd0, ram_enable && wready}, 32'd0);
            if ((ram_enable || wready) && !prev_act)
                chk("turn_precedes", {31'd0, prev_busy}, 32'd1);
            wr_cnt   += int'(ram_write);
            done_cnt += int'(done);
            prev_act  = ram_enable || wready;
            prev_busy = busy;
        end else begin
            prev_act  = 1'b0;
            prev_busy = 1'b0;
        end
    end

    task automatic send_cmd(input bit wr, input int a, input int l);
        int n;
        cmd_valid = 1'b1; cmd_write = wr; cmd_addr = 4'(a); cmd_len = 4'(l);
        n = 0;
        do begin @(negedge clk); n++; end while (!cmd_ready && n < 50);
        chk("cmd_ready", {31'd0, cmd_ready}, 32'd1);
        @(posedge clk); #1;
        cmd_valid = 1'b0;
    endtask

    task automatic wbeat(input int addr, input bit gaps, input logic [7:0] d);
        int g, n;
        g = gaps ? int'($urandom_range(0, 2)) : 0;
        repeat (g) begin
            @(negedge clk);
            chk("gap_no_write", {31'd0, ram_write}, 32'd0);
            @(posedge clk); #1;
        end
        wvalid = 1'b1; wdata = d;
        n = 0;
        do begin @(negedge clk); n++; end while (!wready && n < 20);
        chk("wready", {31'd0, wready}, 32'd1);
        chk("wr_addr", {28'd0, ram_addr}, 32'(addr));
        chk("wr_strobe", {31'd0, ram_write}, 32'd1);
        chk("bus_drive", {24'd0, bus}, {24'd0, d});
        @(posedge clk); #1;
        wvalid = 1'b0;
        ref_mem[addr] = d;
    endtask

    task automatic do_write(input int a, input int l, input bit gaps, input bit fixed, input logic [7:0] base);
        int w0, d0;
        logic [7:0] d;
        w0 = wr_cnt; d0 = done_cnt;
        send_cmd(1'b1, a, l);
        for (int i = 0; i <= l; i++) begin
            d = fixed ? 8'(base + i * 8'h11) : 8'($urandom);
            wbeat((a + i) % 16, gaps, d);
        end
        @(negedge clk);
        chk("wr_done_pulse", {31'd0, done}, 32'd1);
        chk("wr_idle_busy", {31'd0, busy}, 32'd0);
        chk("wr_cmd_ready", {31'd0, cmd_ready}, 32'd1);
        @(posedge clk); #1;
        @(negedge clk);
        chk("wr_done_single", {31'd0, done}, 32'd0);
        chk("wr_count", 32'(wr_cnt - w0), 32'(l + 1));
        chk("wr_done_count", 32'(done_cnt - d0), 32'd1);
        @(posedge clk); #1;
    endtask

    task automatic do_read(input int a, input int l, input bit stall_mode);
        int d0, idx, n, stalls;
        bit held;
        logic [3:0] hold_addr;
        d0 = done_cnt;
        rready = 1'b0;
        send_cmd(1'b0, a, l);
        @(negedge clk);
        chk("turn_no_enable", {31'd0, ram_enable}, 32'd0);
        chk("turn_busy", {31'd0, busy}, 32'd1);
        @(posedge clk); #1;
        @(negedge clk);
        chk("rd_enable", {31'd0, ram_enable}, 32'd1);
        chk("rd_first_addr", {28'd0, ram_addr}, 32'(a));
        chk("rd_not_yet", {31'd0, rvalid}, 32'd0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("rd_latency", {31'd0, rvalid}, 32'd1);
        held = ram_enable; hold_addr = ram_addr;
        @(posedge clk); #1;
        idx = 0; n = 0; stalls = 0;
        while (idx <= l && n < 300) begin
            if (stall_mode) begin
                if (idx == 1 && stalls < 2) begin rready = 1'b0; stalls++; end
                else rready = 1'b1;
            end else begin
                rready = ($urandom % 3) != 0;
            end
            @(negedge clk);
            n++;
            if (held && ram_enable) chk("rd_addr_hold", {28'd0, ram_addr}, {28'd0, hold_addr});
            if (held && rvalid) chk("rd_data_hold", {24'd0, rdata}, {24'd0, ref_mem[(a + idx) % 16]});
            held = ram_enable && rvalid && !rready;
            hold_addr = ram_addr;
            if (rvalid && rready) begin
                chk("rd_data", {24'd0, rdata}, {24'd0, ref_mem[(a + idx) % 16]});
                idx++;
            end
            @(posedge clk); #1;
        end
        rready = 1'b0;
        chk("rd_beats", 32'(idx), 32'(l + 1));
        repeat (3) begin @(posedge clk); #1; end
        @(negedge clk);
        chk("rd_done_count", 32'(done_cnt - d0), 32'd1);
        chk("rd_drained", {31'd0, rvalid}, 32'd0);
        chk("rd_idle", {31'd0, busy}, 32'd0);
        @(posedge clk); #1;
    endtask

    task automatic check_ram();
        for (int i = 0; i < 16; i++) chk("ram_image", {24'd0, ram_mem[i]}, {24'd0, ref_mem[i]});
    endtask

    initial begin
        int d0;
        rst_n = 1'b0; init_ram = 1'b1;
        cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_len = '0;
        wdata = '0; wvalid = 1'b0; rready = 1'b0;
        prev_act = 1'b0; prev_busy = 1'b0;
        for (int i = 0; i < 16; i++) ref_mem[i] = 8'(i * 37 + 11);
        #22;
        chk("rst_addr", {28'd0, ram_addr}, 32'd0);
        chk("rst_enable", {31'd0, ram_enable}, 32'd0);
        chk("rst_write", {31'd0, ram_write}, 32'd0);
        chk("rst_rdata", {24'd0, rdata}, 32'd0);
        chk("rst_rvalid", {31'd0, rvalid}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_wready", {31'd0, wready}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1; init_ram = 1'b0;
        #1;
        chk("rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
        @(posedge clk); #1;
        check_ram();

        do_write(3, 0, 1'b0, 1'b1, 8'hA5);
        do_read(3, 0, 1'b0);
        do_write(14, 3, 1'b0, 1'b1, 8'h11);
        check_ram();
        do_read(14, 3, 1'b0);
        do_read(14, 3, 1'b1);
        do_write(2, 3, 1'b1, 1'b0, 8'h00);
        check_ram();

        // Abort a write burst with reset while a beat is being offered.
        d0 = done_cnt;
        send_cmd(1'b1, 5, 7);
        wbeat(5, 1'b0, 8'h3C);
        wbeat(6, 1'b0, 8'hC3);
        wvalid = 1'b1; wdata = 8'h99;
        @(negedge clk);
        chk("abort_wready", {31'd0, wready}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("abort_write", {31'd0, ram_write}, 32'd0);
        chk("abort_wready_low", {31'd0, wready}, 32'd0);
        chk("abort_enable", {31'd0, ram_enable}, 32'd0);
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_done", {31'd0, done}, 32'd0);
        @(posedge clk);
        @(negedge clk);
        wvalid = 1'b0;
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("abort_no_done", 32'(done_cnt - d0), 32'd0);
        check_ram();
        do_read(5, 3, 1'b0);

        repeat (16) begin
            int a, l;
            a = int'($urandom_range(0, 15));
            l = int'($urandom_range(0, 15));
            if ($urandom % 2) do_write(a, l, 1'b1, 1'b0, 8'h00);
            else do_read(a, l, 1'b0);
        end
        check_ram();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
